// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// State encoding, word width and index-width helper.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read.
// Storage itself is never reset; only the read register is.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage wait-state data memory with pipeline stall and response pulse.
// Optional repeat-load fast path enabled by DMEM_REPEAT_HIT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic        access_err
);

    localparam int AW = idx_width(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW+1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              wr_q, err_q;

    logic              req, in_idle, err_in, hit, fire;
    logic [AW+1:0]     op_addr;
    logic [WORD_W-1:0] op_wdata;
    logic              op_wr, op_err, op_mis;
    logic              unused_addr;

    // Requests are dropped while reset is held so stall clears at once.
    assign req     = (MemRead | MemWrite) & reset;
    assign in_idle = (state_q == ST_IDLE);
    assign err_in  = (address[1:0] != 2'b00) | (MemRead & MemWrite);

    // The completing edge may come straight from IDLE, before latching.
    assign op_addr  = in_idle ? address[AW+1:0] : addr_q;
    assign op_wdata = in_idle ? Write_data : wdata_q;
    assign op_wr    = in_idle ? MemWrite : wr_q;
    assign op_err   = in_idle ? err_in : err_q;
    assign op_mis   = (op_addr[1:0] != 2'b00);

    assign unused_addr = ^address[31:AW+2];

`ifdef DMEM_REPEAT_HIT_EN
    logic [AW-1:0] tag_q;
    logic          tag_vld_q;

    assign hit = MemRead & ~MemWrite & (address[1:0] == 2'b00)
               & tag_vld_q & (tag_q == address[AW+1:2]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if (fire) begin
            tag_q     <= op_addr[AW+1:2];
            tag_vld_q <= ~op_err;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_stall  = 1'b0;
        resp_valid = 1'b0;
        fire       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    if (LATENCY == 1 || hit) begin
                        state_d = ST_DONE;
                        fire    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && req) begin
                addr_q  <= address[AW+1:0];
                wdata_q <= Write_data;
                wr_q    <= MemWrite;
                err_q   <= err_in;
            end
        end
    end

    assign access_err = (state_q == ST_DONE) & err_q;

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (fire & op_wr & ~op_mis),
        .re_i    (fire & ~op_wr & ~op_mis),
        .clr_i   (fire & op_mis),
        .idx_i   (op_addr[AW+1:2]),
        .wdata_i (op_wdata),
        .rdata_o (Read_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Transaction-level reference model plus pinned literal scenarios.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;
`ifdef DMEM_REPEAT_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif
    localparam int HLAT = HIT_EN ? 1 : LAT;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        mem_stall, resp_valid, access_err;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .mem_stall  (mem_stall),
        .resp_valid (resp_valid),
        .access_err (access_err)
    );

    int compared = 0;
    int mismatched = 0;
    bit chk = 1'b0;

    logic        exp_stall = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata = '0;
    int          m_tag = 0;
    bit          m_tag_v = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk) begin
            check("mem_stall", 32'(mem_stall), 32'(exp_stall));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("access_err", 32'(access_err), 32'(exp_err));
            check("Read_data", Read_data, exp_rdata);
        end
    end

    task automatic set_idle();
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = m_rdata;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that
    // follows the completion cycle, with the bus idle.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat_seen, output bit err_seen);
        int  w, lat;
        bit  err, mis, hit;
        w   = int'((a >> 2) % DEPTH);
        mis = (a[1:0] != 2'b00);
        err = mis || (rd && wr);
        hit = HIT_EN && rd && !wr && !mis && m_tag_v && (m_tag == w);
        lat = hit ? 1 : LAT;
        MemRead = rd;
        MemWrite = wr;
        address = a;
        Write_data = d;
        exp_stall = 1'b1;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        lat_seen = -1;
        err_seen = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
                MemRead = 1'($urandom);
                MemWrite = 1'($urandom);
                address = $urandom;
                Write_data = $urandom;
                if (k == lat) begin
                    if (mis) m_rdata = '0;
                    else if (wr) m_mem[w] = d;
                    else m_rdata = m_mem[w];
                    m_tag = w;
                    m_tag_v = !err;
                    exp_stall = 1'b0;
                    exp_valid = 1'b1;
                    exp_err = err;
                    exp_rdata = m_rdata;
                end
            end
            @(negedge clock);
            if (resp_valid && lat_seen < 0) lat_seen = k;
            if (access_err) err_seen = 1'b1;
        end
        @(posedge clock);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        set_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l;
        bit e;
        logic [31:0] a;
        logic [31:0] pa;
        int r;

        #1;
        check("rst_rdata", Read_data, 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_err", 32'(access_err), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        set_idle();
        chk = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), $urandom, l, e);
        end

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, l, e);
        check("store_lat", 32'(l), 32'(LAT));
        access(1'b1, 1'b0, 32'h10, 32'h0, l, e);
        check("load_lat", 32'(l), 32'(HLAT));
        check("load_data", Read_data, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'h13, 32'h0, l, e);
        check("mis_lat", 32'(l), 32'(LAT));
        check("mis_err", 32'(e), 32'h1);
        check("mis_rdata", Read_data, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, l, e);
        check("mis_unchanged", Read_data, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'h400, 32'h1, l, e);
        access(1'b1, 1'b0, 32'h0, 32'h0, l, e);
        check("wrap_data", Read_data, 32'h1);

        access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, l, e);
        check("both_err", 32'(e), 32'h1);
        check("both_hold", Read_data, 32'h1);
        access(1'b1, 1'b0, 32'h30, 32'h0, l, e);
        check("both_store", Read_data, 32'hCAFEF00D);

        access(1'b0, 1'b1, 32'h20, 32'h11112222, l, e);
        MemWrite = 1'b1;
        address = 32'h20;
        Write_data = 32'hAAAA5555;
        exp_stall = 1'b1;
        @(posedge clock);
        #1;
        MemWrite = 1'b0;
        #2;
        chk = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rdata", Read_data, 32'h0);
        check("mid_stall", 32'(mem_stall), 32'h0);
        check("mid_valid", 32'(resp_valid), 32'h0);
        check("mid_err", 32'(access_err), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        m_rdata = '0;
        m_tag_v = 1'b0;
        set_idle();
        chk = 1'b1;
        access(1'b1, 1'b0, 32'h20, 32'h0, l, e);
        check("abort_lat", 32'(l), 32'(LAT));
        check("abort_data", Read_data, 32'h11112222);

        access(1'b1, 1'b0, 32'h40, 32'h0, l, e);
        check("rep1_lat", 32'(l), 32'(LAT));
        access(1'b1, 1'b0, 32'h40, 32'h0, l, e);
        check("rep2_lat", 32'(l), 32'(HLAT));
        access(1'b1, 1'b0, 32'h44, 32'h0, l, e);
        check("rep3_lat", 32'(l), 32'(LAT));

        pa = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                a = pa;
            end else begin
                a = 32'($urandom_range(0, 3)) << 10;
                a = a | (32'($urandom_range(0, 7)) << 2);
                if ($urandom_range(0, 7) == 0)
                    a = a | 32'($urandom_range(1, 3));
            end
            pa = a;
            r = $urandom_range(0, 9);
            access(r < 5 || r == 9, r >= 5, a, $urandom, l, e);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
